// File: rtl/mpmc11_app_rd_data_collect.sv
// Collects DDR app read beats into lines using the burst length queued per read
// command, and hands completed lines plus tags to the port over valid/ready.
module mpmc11_app_rd_data_collect #(
  parameter int DW        = 128,
  parameter int MAX_BEATS = 4,
  parameter int TAGW      = 8,
  parameter int QDEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_accept,
  input  logic [TAGW-1:0]         cmd_tag,
  input  logic [5:0]              cmd_burst_len,
  input  logic                    rd_data_valid,
  input  logic                    rd_data_end,
  input  logic [DW-1:0]           rd_data,
  output logic                    line_valid,
  input  logic                    line_ready,
  output logic [DW*MAX_BEATS-1:0] line_data,
  output logic [TAGW-1:0]         line_tag,
  output logic                    q_full,
  output logic                    busy,
  output logic                    err_orphan,
  output logic                    err_end,
  output logic                    err_ovf,
  output logic                    err_qovf
);

  localparam int         BW     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int         QAW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [5:0] MAXIDX = 6'(MAX_BEATS - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  logic [TAGW-1:0] r_q_tag  [QDEPTH];
  logic [BW-1:0]   r_q_blen [QDEPTH];
  logic [QAW-1:0]  r_q_wp, r_q_rp;
  logic [QAW:0]    r_q_cnt;

  state_t          r_state, w_state_nxt;
  logic [BW-1:0]   r_burst_cnt, w_cnt_nxt;
  logic [DW-1:0]   r_asm [MAX_BEATS];
  logic [DW*MAX_BEATS-1:0] w_line;

  logic [DW*MAX_BEATS-1:0] r_ob_data [2];
  logic [TAGW-1:0]         r_ob_tag  [2];
  logic                    r_ob_wp, r_ob_rp;
  logic [1:0]              r_ob_cnt;

  logic            w_q_empty, w_q_full, w_beat, w_last, w_push, w_pop;
  logic            w_xfer, w_ob_push, w_ob_full;
  logic [BW-1:0]   w_blen, w_head_blen;
  logic [TAGW-1:0] w_head_tag;

  assign w_q_empty   = (r_q_cnt == '0);
  assign w_q_full    = (r_q_cnt == (QAW+1)'(QDEPTH));
  assign w_head_blen = r_q_blen[r_q_rp];
  assign w_head_tag  = r_q_tag[r_q_rp];
  assign w_beat      = rd_data_valid && !w_q_empty;
  assign w_last      = w_beat && (r_burst_cnt == w_head_blen);
  assign w_pop       = w_last;
  // A pop in the same cycle frees the slot, so a push at full is still legal then.
  assign w_push      = cmd_accept && (!w_q_full || w_pop);
  assign w_blen      = (cmd_burst_len > MAXIDX) ? BW'(MAXIDX) : BW'(cmd_burst_len);

  assign w_ob_full   = (r_ob_cnt == 2'd2);
  assign w_xfer      = line_valid && line_ready;
  assign w_ob_push   = w_last && (!w_ob_full || w_xfer);

  assign line_valid  = (r_ob_cnt != 2'd0);
  assign line_data   = r_ob_data[r_ob_rp];
  assign line_tag    = r_ob_tag[r_ob_rp];
  assign q_full      = w_q_full;
  assign busy        = !w_q_empty || (r_state == COLLECT) || line_valid;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_tag[r_q_wp]  <= cmd_tag;
      r_q_blen[r_q_wp] <= w_blen;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_wp  <= '0;
      r_q_rp  <= '0;
      r_q_cnt <= '0;
    end else begin
      if (w_push) r_q_wp <= r_q_wp + 1'b1;
      if (w_pop)  r_q_rp <= r_q_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_q_cnt <= r_q_cnt + 1'b1;
        2'b01:   r_q_cnt <= r_q_cnt - 1'b1;
        default: r_q_cnt <= r_q_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_burst_cnt;
    if (w_beat) begin
      if (w_last) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = COLLECT;
        w_cnt_nxt   = r_burst_cnt + 1'b1;
      end
    end
  end

  // The first beat of a line zeroes the higher slots so short reads pad with 0.
  always_comb begin
    w_line = '0;
    for (int i = 0; i < MAX_BEATS; i++) begin
      if (BW'(i) == r_burst_cnt)
        w_line[i*DW +: DW] = rd_data;
      else if (r_burst_cnt == '0)
        w_line[i*DW +: DW] = '0;
      else
        w_line[i*DW +: DW] = r_asm[i];
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat) begin
      for (int i = 0; i < MAX_BEATS; i++)
        r_asm[i] <= w_line[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_ob_data[i] <= '0;
        r_ob_tag[i]  <= '0;
      end
      r_ob_wp  <= 1'b0;
      r_ob_rp  <= 1'b0;
      r_ob_cnt <= 2'd0;
    end else begin
      if (w_ob_push) begin
        r_ob_data[r_ob_wp] <= w_line;
        r_ob_tag[r_ob_wp]  <= w_head_tag;
        r_ob_wp            <= ~r_ob_wp;
      end
      if (w_xfer) r_ob_rp <= ~r_ob_rp;
      case ({w_ob_push, w_xfer})
        2'b10:   r_ob_cnt <= r_ob_cnt + 1'b1;
        2'b01:   r_ob_cnt <= r_ob_cnt - 1'b1;
        default: r_ob_cnt <= r_ob_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_orphan <= 1'b0;
      err_end    <= 1'b0;
      err_ovf    <= 1'b0;
      err_qovf   <= 1'b0;
    end else begin
      if (rd_data_valid && w_q_empty)                              err_orphan <= 1'b1;
      if (w_beat && (rd_data_end != (r_burst_cnt == w_head_blen))) err_end    <= 1'b1;
      if (w_last && w_ob_full && !w_xfer)                          err_ovf    <= 1'b1;
      if (cmd_accept && w_q_full && !w_pop)                        err_qovf   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mpmc11_app_rd_data_collect.sv
// Directed bench for mpmc11_app_rd_data_collect: one task per scenario with
// hand-computed expected lines, tags and flags.
module tb_mpmc11_app_rd_data_collect;
  localparam int DW = 128, MB = 4, TAGW = 8, QD = 4, LW = DW*MB;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_accept = 1'b0;
  logic [TAGW-1:0] cmd_tag = '0;
  logic [5:0]      cmd_burst_len = '0;
  logic            rd_data_valid = 1'b0;
  logic            rd_data_end = 1'b0;
  logic [DW-1:0]   rd_data = '0;
  logic            line_valid;
  logic            line_ready = 1'b1;
  logic [LW-1:0]   line_data;
  logic [TAGW-1:0] line_tag;
  logic            q_full, busy, err_orphan, err_end, err_ovf, err_qovf;

  int checks = 0;
  int errors = 0;

  mpmc11_app_rd_data_collect #(.DW(DW), .MAX_BEATS(MB), .TAGW(TAGW), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .cmd_accept(cmd_accept), .cmd_tag(cmd_tag),
    .cmd_burst_len(cmd_burst_len), .rd_data_valid(rd_data_valid),
    .rd_data_end(rd_data_end), .rd_data(rd_data), .line_valid(line_valid),
    .line_ready(line_ready), .line_data(line_data), .line_tag(line_tag),
    .q_full(q_full), .busy(busy), .err_orphan(err_orphan), .err_end(err_end),
    .err_ovf(err_ovf), .err_qovf(err_qovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [TAGW-1:0] tag, input logic [5:0] len);
    cmd_accept = 1'b1; cmd_tag = tag; cmd_burst_len = len;
    tick();
    cmd_accept = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if ({line_valid, busy, q_full, err_orphan, err_end, err_ovf, err_qovf} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0", {line_valid, busy, q_full, err_orphan, err_end, err_ovf, err_qovf});
    end
    checks++; if (line_data !== '0 || line_tag !== '0) begin
      errors++; $display("FAIL reset_data got %0h/%0h exp 0", line_data, line_tag);
    end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [LW-1:0] exp_line;
    exp_line = {128'hD, 128'hC, 128'hB, 128'hA};
    line_ready = 1'b1;
    push_cmd(8'h12, 6'd3);
    for (int i = 0; i < 4; i++) begin
      rd_data_valid = 1'b1; rd_data = DW'(32'hA + i); rd_data_end = (i == 3);
      tick();
      if (i == 2) begin
        checks++; if (line_valid !== 1'b0) begin
          errors++; $display("FAIL single_early got %b exp 0", line_valid);
        end
      end
    end
    rd_data_valid = 1'b0; rd_data_end = 1'b0;
    checks++; if (line_valid !== 1'b1 || line_tag !== 8'h12) begin
      errors++; $display("FAIL single_valid got %b/%0h exp 1/12", line_valid, line_tag);
    end
    checks++; if (line_data !== exp_line) begin
      errors++; $display("FAIL single_data got %0h exp %0h", line_data, exp_line);
    end
    checks++; if ({err_orphan, err_end, err_ovf, err_qovf} !== 4'b0) begin
      errors++; $display("FAIL single_flags got %b exp 0", {err_orphan, err_end, err_ovf, err_qovf});
    end
    tick();
    checks++; if (line_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_drain got %b%b exp 00", line_valid, busy);
    end
  endtask

  task automatic test_gap();
    logic [LW-1:0] exp_line;
    exp_line = {128'h0, 128'h0, 128'h222, 128'h111};
    push_cmd(8'h34, 6'd1);
    rd_data_valid = 1'b1; rd_data = 128'h111; rd_data_end = 1'b0;
    tick();
    rd_data_valid = 1'b0;
    tick();
    checks++; if (busy !== 1'b1 || line_valid !== 1'b0) begin
      errors++; $display("FAIL gap_mid got busy %b valid %b exp 1/0", busy, line_valid);
    end
    rd_data_valid = 1'b1; rd_data = 128'h222; rd_data_end = 1'b1;
    tick();
    rd_data_valid = 1'b0; rd_data_end = 1'b0;
    checks++; if (line_valid !== 1'b1 || line_tag !== 8'h34 || line_data !== exp_line) begin
      errors++; $display("FAIL gap_line got %b/%0h/%0h exp 1/34/%0h", line_valid, line_tag, line_data, exp_line);
    end
    tick();
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL gap_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_back_pressure();
    line_ready = 1'b0;
    push_cmd(8'd1, 6'd0);
    push_cmd(8'd2, 6'd0);
    push_cmd(8'd3, 6'd0);
    for (int i = 1; i <= 3; i++) begin
      rd_data_valid = 1'b1; rd_data = DW'(i); rd_data_end = 1'b1;
      tick();
      checks++; if (line_valid !== 1'b1 || line_tag !== 8'd1 || line_data !== LW'(128'h1)) begin
        errors++; $display("FAIL bp_hold%0d got %b/%0h/%0h exp 1/1/1", i, line_valid, line_tag, line_data);
      end
    end
    rd_data_valid = 1'b0; rd_data_end = 1'b0;
    checks++; if (err_ovf !== 1'b1) begin
      errors++; $display("FAIL bp_ovf got %b exp 1", err_ovf);
    end
    line_ready = 1'b1;
    tick();
    checks++; if (line_valid !== 1'b1 || line_tag !== 8'd2 || line_data !== LW'(128'h2)) begin
      errors++; $display("FAIL bp_second got %b/%0h/%0h exp 1/2/2", line_valid, line_tag, line_data);
    end
    tick();
    checks++; if (line_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_lost3 got %b%b exp 00", line_valid, busy);
    end
  endtask

  task automatic test_orphan();
    checks++; if (err_orphan !== 1'b0) begin
      errors++; $display("FAIL orphan_pre got %b exp 0", err_orphan);
    end
    rd_data_valid = 1'b1; rd_data = 128'hBAD; rd_data_end = 1'b1;
    tick();
    rd_data_valid = 1'b0; rd_data_end = 1'b0;
    tick();
    checks++; if (err_orphan !== 1'b1 || line_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL orphan got %b%b%b exp 100", err_orphan, line_valid, busy);
    end
  endtask

  task automatic test_end_err();
    logic [LW-1:0] exp_line;
    exp_line = {128'h54, 128'h53, 128'h52, 128'h51};
    checks++; if (err_end !== 1'b0) begin
      errors++; $display("FAIL end_pre got %b exp 0", err_end);
    end
    push_cmd(8'h55, 6'd3);
    for (int i = 0; i < 4; i++) begin
      rd_data_valid = 1'b1; rd_data = DW'(32'h51 + i); rd_data_end = (i == 1);
      tick();
      if (i == 1) begin
        checks++; if (err_end !== 1'b1 || line_valid !== 1'b0) begin
          errors++; $display("FAIL end_flag got %b/%b exp 1/0", err_end, line_valid);
        end
      end
    end
    rd_data_valid = 1'b0; rd_data_end = 1'b0;
    checks++; if (line_valid !== 1'b1 || line_tag !== 8'h55 || line_data !== exp_line) begin
      errors++; $display("FAIL end_line got %b/%0h/%0h exp 1/55/%0h", line_valid, line_tag, line_data, exp_line);
    end
    tick();
  endtask

  task automatic test_queue_limits();
    logic [LW-1:0] exp_line;
    exp_line = {128'h64, 128'h63, 128'h62, 128'h61};
    push_cmd(8'h60, 6'd10);
    push_cmd(8'h61, 6'd0);
    push_cmd(8'h62, 6'd0);
    checks++; if (q_full !== 1'b0) begin
      errors++; $display("FAIL q_notfull got %b exp 0", q_full);
    end
    push_cmd(8'h63, 6'd0);
    checks++; if (q_full !== 1'b1 || err_qovf !== 1'b0) begin
      errors++; $display("FAIL q_full4 got %b/%b exp 1/0", q_full, err_qovf);
    end
    for (int i = 0; i < 4; i++) begin
      rd_data_valid = 1'b1; rd_data = DW'(32'h61 + i); rd_data_end = (i == 3);
      if (i == 3) begin
        cmd_accept = 1'b1; cmd_tag = 8'h64; cmd_burst_len = 6'd0;
      end
      tick();
      if (i == 2) begin
        checks++; if (line_valid !== 1'b0) begin
          errors++; $display("FAIL clamp_early got %b exp 0", line_valid);
        end
      end
    end
    cmd_accept = 1'b0; rd_data_valid = 1'b0; rd_data_end = 1'b0;
    checks++; if (line_valid !== 1'b1 || line_tag !== 8'h60 || line_data !== exp_line) begin
      errors++; $display("FAIL clamp_line got %b/%0h/%0h exp 1/60/%0h", line_valid, line_tag, line_data, exp_line);
    end
    checks++; if (q_full !== 1'b1 || err_qovf !== 1'b0) begin
      errors++; $display("FAIL q_pushpop got %b/%b exp 1/0", q_full, err_qovf);
    end
    push_cmd(8'h65, 6'd0);
    checks++; if (err_qovf !== 1'b1) begin
      errors++; $display("FAIL q_ovf got %b exp 1", err_qovf);
    end
    for (int i = 1; i <= 4; i++) begin
      rd_data_valid = 1'b1; rd_data = DW'(i); rd_data_end = 1'b1;
      tick();
      checks++; if (line_valid !== 1'b1 || line_tag !== TAGW'(8'h60 + i)) begin
        errors++; $display("FAIL q_drain%0d got %b/%0h exp 1/%0h", i, line_valid, line_tag, 8'h60 + i);
      end
    end
    rd_data_valid = 1'b0; rd_data_end = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || q_full !== 1'b0) begin
      errors++; $display("FAIL q_empty got busy %b full %b exp 0/0", busy, q_full);
    end
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] exp_line;
    exp_line = {128'h4, 128'h3, 128'h2, 128'h1};
    push_cmd(8'h77, 6'd3);
    for (int i = 0; i < 2; i++) begin
      rd_data_valid = 1'b1; rd_data = DW'(32'hE0 + i); rd_data_end = 1'b0;
      tick();
    end
    rd_data_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if ({line_valid, busy, q_full, err_orphan, err_end, err_ovf, err_qovf} !== 7'b0) begin
      errors++; $display("FAIL rst_mid got %b exp 0", {line_valid, busy, q_full, err_orphan, err_end, err_ovf, err_qovf});
    end
    #1 rst = 1'b0;
    tick();
    push_cmd(8'h78, 6'd3);
    for (int i = 0; i < 4; i++) begin
      rd_data_valid = 1'b1; rd_data = DW'(i + 1); rd_data_end = (i == 3);
      tick();
    end
    rd_data_valid = 1'b0; rd_data_end = 1'b0;
    checks++; if (line_valid !== 1'b1 || line_tag !== 8'h78 || line_data !== exp_line) begin
      errors++; $display("FAIL rst_fresh got %b/%0h/%0h exp 1/78/%0h", line_valid, line_tag, line_data, exp_line);
    end
    checks++; if (err_end !== 1'b0) begin
      errors++; $display("FAIL rst_fresh_end got %b exp 0", err_end);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_back_pressure();
    test_orphan();
    test_end_err();
    test_queue_limits();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/mpmc11_app_rd_data_collect.md
Name: mpmc11_app_rd_data_collect

Overview:
- Read-return counterpart to the write-data end generator. It captures read beats from the DDR controller app interface (app_rd_data, app_rd_data_valid, app_rd_data_end).
- Beats are counted against the burst length queued when each read command was accepted, then assembled into a line. Each completed line, with its request tag, goes to the port response logic over a valid/ready handshake.
- The controller cannot be back-pressured, so the block holds a 2-entry output buffer and sticky error flags.

Parameters:
- DW, 128, app data width per beat.
- MAX_BEATS, 4, maximum beats per line. Line width is DW*MAX_BEATS.
- TAGW, 8, request tag width.
- QDEPTH, 4, outstanding-read queue depth (power of 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cmd_accept  in  1  read command accepted by controller this cycle
- cmd_tag  in  TAGW  tag of accepted read
- cmd_burst_len  in  6  last beat index of the accepted read (beats-1)
- rd_data_valid  in  1  app_rd_data_valid
- rd_data_end  in  1  app_rd_data_end
- rd_data  in  DW  app_rd_data
- line_valid  out  1  completed line available
- line_ready  in  1  consumer accepts line
- line_data  out  DW*MAX_BEATS  assembled line; beat 0 in the LSBs
- line_tag  out  TAGW  tag of line
- q_full  out  1  outstanding queue full
- busy  out  1  queue non-empty or line in progress
- err_orphan  out  1  sticky: beat arrived with no outstanding read
- err_end  out  1  sticky: rd_data_end disagrees with beat count
- err_ovf  out  1  sticky: line completed while output buffer full
- err_qovf  out  1  sticky: cmd_accept while q_full

Behaviour:
- Reset (async, rst=1): all outputs and flags go to 0, queue empty, state IDLE, burst_cnt=0, line_data=0, line_tag=0.
- Queue:
  - cmd_accept && !q_full pushes {cmd_tag, blen}. blen = min(cmd_burst_len, MAX_BEATS-1).
  - cmd_accept && q_full drops the command and sets err_qovf.
  - A push and a pop in the same cycle are both performed; occupancy is unchanged.
- State machine: IDLE (burst_cnt=0) and COLLECT (burst_cnt>0).
  - On rd_data_valid with the queue empty: the beat is dropped, err_orphan is set, and the state is unchanged.
  - Otherwise rd_data is written to assembly slot burst_cnt.
  - On entering a line (IDLE), the assembly slots above beat 0 are cleared to 0, so unused beats read as zero.
  - If burst_cnt==head.blen: the line completes, the queue pops, burst_cnt=0, state goes to IDLE. Otherwise burst_cnt increments and state goes to COLLECT.
  - err_end is set if rd_data_end differs from (burst_cnt==head.blen). The count always governs; rd_data_end never terminates a line.
- Output buffer (2 entries, FIFO order):
  - A completed line enters the buffer at the clock edge of its last beat. line_valid is high the next cycle, a latency of 1 cycle after the last beat.
  - Transfer occurs on line_valid && line_ready.
  - line_data and line_tag are stable while line_valid && !line_ready.
  - Completion with both entries full drops the line and sets err_ovf. The queue pop still occurs.
  - Completion and transfer in the same cycle with the buffer full is accepted; no overflow.
- busy = queue non-empty || state==COLLECT || line_valid.
- Sticky error flags clear only on rst.
- Non-valid cycles inside a burst (gaps) are permitted: counting resumes on the next valid beat.
- rst mid-burst aborts the partial line and discards queued tags and buffered lines.

Test Plan:
- Single 4-beat read: push tag 0x12, blen=3; beats 0xA..0xD on consecutive cycles, rd_data_end on beat 3, line_ready=1 -> line_valid one cycle after beat 3; line_data = {D,C,B,A}; line_tag=0x12; no error flags.
- Short read plus gaps: blen=1 with an idle cycle between beats -> line completes on the second valid beat; upper two beat slots are 0; busy drops the cycle after transfer.
- Back-pressure: three back-to-back 1-beat reads (tags 1,2,3) with line_ready=0 -> lines 1 and 2 held stable; third completion sets err_ovf and line 3 is lost; releasing line_ready yields tags 1 then 2.
- Error paths:
  - rd_data_valid with empty queue sets err_orphan and no line is produced.
  - rd_data_end asserted on beat 1 of a blen=3 read sets err_end; the line still completes after beat 3.
- Queue limits:
  - 5 cmd_accepts with no data give q_full after 4 and err_qovf on the 5th.
  - A simultaneous push and completion-pop at full leaves occupancy at 4 with no err_qovf.
  - cmd_burst_len=10 is clamped to 3.
- Reset mid-burst: after 2 of 4 beats, pulse rst asynchronously (between clock edges) -> all outputs 0 immediately; a subsequent fresh read completes correctly with burst_cnt restarting at 0.
